// File: rtl/axi_decerr_slave.sv
// axi_decerr_slave: default AXI target that answers every burst with DECERR
// and logs the address and a saturating count of the requests it accepted.
module axi_decerr_slave #(
  parameter int unsigned          IdWidth   = 5,
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 err_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [15:0]          err_cnt_o
);

  localparam logic [1:0] DecErr = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [IdWidth-1:0] b_id_q;
  logic [IdWidth-1:0] r_id_q;
  logic [7:0]         r_cnt_q;
  logic               aw_hs, ar_hs, r_hs;
  logic [1:0]         inc;
  logic [16:0]        cnt_sum;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_o & r_ready_i;

  assign b_id_o   = b_id_q;
  assign b_resp_o = DecErr;
  assign r_id_o   = r_id_q;
  assign r_data_o = RespData;
  assign r_resp_o = DecErr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      b_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) b_id_q <= aw_id_i;
    end
  end

  // W data is never stored; only the last beat matters
  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_id_q  <= ar_id_i;
        r_cnt_q <= ar_len_i;
      end else if (r_hs && r_cnt_q != 8'd0) begin
        r_cnt_q <= r_cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        r_last_o  = (r_cnt_q == 8'd0);
        if (r_ready_i && r_last_o) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign inc     = {1'b0, aw_hs} + {1'b0, ar_hs};
  assign cnt_sum = {1'b0, err_cnt_o} + {15'd0, inc};

  // AW wins the address log when both channels fire together
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      err_o <= aw_hs | ar_hs;
      if (aw_hs) err_addr_o <= aw_addr_i;
      else if (ar_hs) err_addr_o <= ar_addr_i;
      err_cnt_o <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Bench for axi_decerr_slave: directed steps with a B/R scoreboard
// and a cycle model of the error log.
module tb_axi_decerr_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        aw_valid, aw_ready;
  logic [4:0]  aw_id;
  logic [63:0] aw_addr;
  logic        w_valid, w_ready, w_last;
  logic        b_valid, b_ready;
  logic [4:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [4:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_valid, r_ready;
  logic [4:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        err;
  logic [63:0] err_addr;
  logic [15:0] err_cnt;

  axi_decerr_slave dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready),
    .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready),
    .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .err_o(err), .err_addr_o(err_addr), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] id;
    logic       last;
  } rexp_t;

  int checks = 0;
  int errors = 0;

  logic [4:0] bq[$];
  rexp_t      rq[$];

  bit          mon_on  = 1'b0;
  logic        exp_err = 1'b0;
  logic [63:0] exp_addr = '0;
  logic [15:0] exp_cnt = '0;
  int          c;
  rexp_t       re;
  logic [4:0]  be;
  bit          r_stall = 1'b0;
  bit          b_stall = 1'b0;
  logic [4:0]  s_rid, s_bid;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_rlast;
  logic [63:0] s_rdata;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks results of the last edge, then models the next edge
  always @(negedge clk) begin
    if (mon_on) begin
      chk("err_o", 64'(err), 64'(exp_err));
      chk("err_addr", err_addr, exp_addr);
      chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
      if (r_stall) begin
        chk("r_hold_valid", 64'(r_valid), 64'd1);
        chk("r_hold_id", 64'(r_id), 64'(s_rid));
        chk("r_hold_last", 64'(r_last), 64'(s_rlast));
        chk("r_hold_resp", 64'(r_resp), 64'(s_rresp));
        chk("r_hold_data", r_data, s_rdata);
      end
      if (b_stall) begin
        chk("b_hold_valid", 64'(b_valid), 64'd1);
        chk("b_hold_id", 64'(b_id), 64'(s_bid));
        chk("b_hold_resp", 64'(b_resp), 64'(s_bresp));
      end
      if (b_valid && b_ready && !rst) begin
        chk("b_expected", 64'(bq.size() != 0), 64'd1);
        if (bq.size() != 0) begin
          be = bq.pop_front();
          chk("b_id", 64'(b_id), 64'(be));
          chk("b_resp", 64'(b_resp), 64'd3);
        end
      end
      if (r_valid && r_ready && !rst) begin
        chk("r_expected", 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0) begin
          re = rq.pop_front();
          chk("r_id", 64'(r_id), 64'(re.id));
          chk("r_last", 64'(r_last), 64'(re.last));
          chk("r_resp", 64'(r_resp), 64'd3);
          chk("r_data", r_data, 64'hDEAD_BEEF_DEAD_BEEF);
        end
      end
      r_stall = r_valid && !r_ready && !rst;
      b_stall = b_valid && !b_ready && !rst;
      s_rid = r_id; s_rlast = r_last; s_rresp = r_resp; s_rdata = r_data;
      s_bid = b_id; s_bresp = b_resp;
      if (rst) begin
        exp_err = 1'b0; exp_addr = '0; exp_cnt = '0;
        bq.delete(); rq.delete();
      end else begin
        exp_err = (aw_valid && aw_ready) || (ar_valid && ar_ready);
        if (aw_valid && aw_ready) exp_addr = aw_addr;
        else if (ar_valid && ar_ready) exp_addr = ar_addr;
        c = int'(exp_cnt) + int'(aw_valid && aw_ready)
            + int'(ar_valid && ar_ready);
        exp_cnt = (c > 65535) ? 16'hFFFF : 16'(c);
        if (aw_valid && aw_ready) bq.push_back(aw_id);
        if (ar_valid && ar_ready)
          for (int i = 0; i <= int'(ar_len); i++)
            rq.push_back('{id: ar_id, last: (i == int'(ar_len))});
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0 || b_valid || r_valid ||
            !aw_ready || !ar_ready) && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_aw_ready"}, 64'(aw_ready), 64'd1);
    chk({tag, "_ar_ready"}, 64'(ar_ready), 64'd1);
    chk({tag, "_w_ready"}, 64'(w_ready), 64'd0);
    chk({tag, "_b_valid"}, 64'(b_valid), 64'd0);
    chk({tag, "_r_valid"}, 64'(r_valid), 64'd0);
    chk({tag, "_r_last"}, 64'(r_last), 64'd0);
  endtask

  int nb;
  int total;
  int hs;

  initial begin
    rst = 1'b1;
    aw_valid = 0; aw_id = '0; aw_addr = '0;
    w_valid = 0; w_last = 0; b_ready = 1;
    ar_valid = 0; ar_id = '0; ar_addr = '0; ar_len = '0;
    r_ready = 1;
    step(); step();
    idle_outs("rst");
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_err_addr", err_addr, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    mon_on = 1'b1;
    rst = 1'b0;
    step();
    idle_outs("post_rst");

    // W beats without AW stay pending
    w_valid = 1; w_last = 1;
    repeat (3) begin
      step();
      chk("w_idle_ready", 64'(w_ready), 64'd0);
    end
    chk("w_idle_cnt", 64'(err_cnt), 64'd0);
    w_valid = 0; w_last = 0;

    // four-beat write
    aw_valid = 1; aw_id = 5'h13; aw_addr = 64'h4000_0000;
    step();
    aw_valid = 0;
    chk("wr_w_ready", 64'(w_ready), 64'd1);
    chk("wr_aw_ready", 64'(aw_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      w_valid = 1; w_last = (i == 3);
      step();
    end
    w_valid = 0; w_last = 0;
    chk("wr_b_valid", 64'(b_valid), 64'd1);
    wait_idle(20);
    chk("wr_err_addr", err_addr, 64'h4000_0000);
    chk("wr_err_cnt", 64'(err_cnt), 64'd1);

    // four-beat read
    ar_valid = 1; ar_id = 5'h07; ar_len = 8'd3; ar_addr = 64'h4000_1000;
    step();
    ar_valid = 0;
    chk("rd_r_valid", 64'(r_valid), 64'd1);
    wait_idle(20);
    chk("rd_err_cnt", 64'(err_cnt), 64'd2);
    chk("rd_err_addr", err_addr, 64'h4000_1000);

    // R backpressure
    ar_valid = 1; ar_id = 5'h0A; ar_len = 8'd0; ar_addr = 64'h4000_2000;
    r_ready = 0;
    step();
    ar_valid = 0;
    repeat (5) begin
      chk("bp_r_valid", 64'(r_valid), 64'd1);
      chk("bp_ar_ready", 64'(ar_ready), 64'd0);
      step();
    end
    r_ready = 1;
    wait_idle(20);
    chk("bp_err_cnt", 64'(err_cnt), 64'd3);

    // AW and AR in the same cycle
    aw_valid = 1; aw_id = 5'h01; aw_addr = 64'h5000_0000;
    ar_valid = 1; ar_id = 5'h02; ar_addr = 64'h6000_0000; ar_len = 8'd1;
    step();
    aw_valid = 0; ar_valid = 0;
    chk("sim_err", 64'(err), 64'd1);
    chk("sim_err_cnt", 64'(err_cnt), 64'd5);
    chk("sim_err_addr", err_addr, 64'h5000_0000);
    w_valid = 1; w_last = 1;
    step();
    w_valid = 0; w_last = 0;
    wait_idle(20);

    // reset during beat 2 of a 256-beat read
    ar_valid = 1; ar_id = 5'h03; ar_len = 8'd255; ar_addr = 64'h7000_0000;
    step();
    ar_valid = 0;
    step(); step();
    chk("mid_r_valid", 64'(r_valid), 64'd1);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_r_valid", 64'(r_valid), 64'd0);
    chk("mrst_err_cnt", 64'(err_cnt), 64'd0);
    step();
    idle_outs("mrst");
    ar_valid = 1; ar_id = 5'h04; ar_len = 8'd0;
    step();
    ar_valid = 0;
    chk("after_rst_r_valid", 64'(r_valid), 64'd1);
    chk("after_rst_r_last", 64'(r_last), 64'd1);
    wait_idle(20);

    // 256-beat read
    ar_valid = 1; ar_id = 5'h1F; ar_len = 8'd255;
    step();
    ar_valid = 0;
    nb = 0;
    for (int k = 0; k < 400; k++) begin
      if (!r_valid) break;
      if (r_ready) nb++;
      step();
    end
    chk("max_len_beats", 64'(nb), 64'd256);
    wait_idle(20);
    chk("max_len_err_cnt", 64'(err_cnt), 64'd2);

    // drive the counter to 16'hFFFF at full rate
    total = 2;
    w_valid = 1; w_last = 1;
    for (int it = 0; it < 95000 && total < 65535; it++) begin
      aw_valid = 1; ar_valid = 1; ar_len = 8'd0;
      aw_id = 5'(total); ar_id = 5'(total + 1);
      aw_addr = 64'(total); ar_addr = 64'h8000_0000 + 64'(total);
      hs = int'(aw_ready) + int'(ar_ready);
      if (total + hs > 65535) begin
        ar_valid = 0;
        hs = hs - 1;
      end
      total += hs;
      step();
    end
    aw_valid = 0; ar_valid = 0;
    chk("flood_reached", 64'(total), 64'd65535);
    wait_idle(20);
    w_valid = 0; w_last = 0;
    chk("sat_full", 64'(err_cnt), 64'hFFFF);

    ar_valid = 1; ar_id = 5'h05; ar_len = 8'd0; ar_addr = 64'h9000_0000;
    step();
    ar_valid = 0;
    wait_idle(20);
    chk("sat_plus1", 64'(err_cnt), 64'hFFFF);
    chk("sat_addr", err_addr, 64'h9000_0000);

    aw_valid = 1; aw_id = 5'h06; aw_addr = 64'hA000_0000;
    ar_valid = 1; ar_id = 5'h08; ar_addr = 64'hB000_0000;
    step();
    aw_valid = 0; ar_valid = 0;
    w_valid = 1; w_last = 1;
    step();
    w_valid = 0; w_last = 0;
    wait_idle(20);
    chk("sat_plus2", 64'(err_cnt), 64'hFFFF);
    chk("sat_aw_addr", err_addr, 64'hA000_0000);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_decerr_slave.md
AXI_DECERR_SLAVE -- requirements
Module: axi_decerr_slave

Interface
REQ-001 SHALL have parameter IdWidth, default 5, giving the AXI ID width seen at a crossbar slave port (IdWidth 4 + clog2(2 masters)).
REQ-002 SHALL have parameter AddrWidth, default 64, giving the AXI address width.
REQ-003 SHALL have parameter DataWidth, default 64, giving the AXI data width.
REQ-004 SHALL have parameter RespData, default 64'hDEAD_BEEF_DEAD_BEEF, giving the R data returned on every beat.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports are as follows; clock and reset come first:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- aw_valid_i  in  1; aw_ready_o  out  1; aw_id_i  in  IdWidth; aw_addr_i  in  AddrWidth
- w_valid_i  in  1; w_ready_o  out  1; w_last_i  in  1 (w_data/w_strb are not connected and are ignored)
- b_valid_o  out  1; b_ready_i  in  1; b_id_o  out  IdWidth; b_resp_o  out  2
- ar_valid_i  in  1; ar_ready_o  out  1; ar_id_i  in  IdWidth; ar_addr_i  in  AddrWidth; ar_len_i  in  8
- r_valid_o  out  1; r_ready_i  in  1; r_id_o  out  IdWidth; r_data_o  out  DataWidth; r_resp_o  out  2; r_last_o  out  1
- err_o  out  1  one-cycle pulse when any AW or AR is accepted
- err_addr_o  out  AddrWidth  address of the most recently logged error
- err_cnt_o  out  16  saturating count of accepted erroneous transactions

Function
REQ-007 The block SHALL respond to every transaction with DECERR (2'b11) on b_resp_o and r_resp_o; it is the default target for unmapped regions of the SoC map, for example 0x4000_0000.
REQ-008 A handshake SHALL occur only when valid and ready are both high on a rising clock edge.
REQ-009 The write FSM SHALL have three states: W_IDLE, W_DATA, W_RESP.
REQ-010 In W_IDLE, aw_ready_o SHALL be 1. On an AW handshake the FSM SHALL latch aw_id_i and go to W_DATA.
REQ-011 In W_DATA, w_ready_o SHALL be 1 and every W beat SHALL be discarded. A W handshake with w_last_i=1 SHALL move the FSM to W_RESP.
REQ-012 In W_RESP, b_valid_o SHALL be 1, b_id_o SHALL equal the latched ID, and b_resp_o SHALL be 2'b11. A B handshake SHALL return the FSM to W_IDLE.
REQ-013 aw_ready_o SHALL be 0 outside W_IDLE, w_ready_o SHALL be 0 outside W_DATA, and b_valid_o SHALL be 0 outside W_RESP.
REQ-014 The read FSM SHALL have two states: R_IDLE and R_DATA.
REQ-015 In R_IDLE, ar_ready_o SHALL be 1. On an AR handshake the FSM SHALL latch ar_id_i, load an 8-bit beat counter with ar_len_i, and go to R_DATA.
REQ-016 In R_DATA, r_valid_o SHALL be 1, r_data_o SHALL equal RespData, r_resp_o SHALL be 2'b11, and r_last_o SHALL be 1 exactly when the counter is 0.
REQ-017 Each R handshake SHALL decrement the counter. An R handshake with r_last_o=1 SHALL return the FSM to R_IDLE. Exactly ar_len_i+1 beats SHALL be emitted, so ar_len_i=255 gives 256 beats with no wrap.
REQ-018 The read and write FSMs SHALL be fully independent and may both be busy at the same time.
REQ-019 Minimum latency SHALL be one cycle from address handshake to the first valid R or W-ready. A burst SHALL take 3 cycles for a single-beat write (AW, W, B) and 2 cycles for a single-beat read.
REQ-020 While its output is stalled by ready=0, every output (valid, id, data, resp, last) SHALL stay stable.
REQ-021 err_o SHALL pulse high for one cycle, registered, in the cycle after any AW or AR handshake.
REQ-022 err_addr_o SHALL update together with err_o. If AW and AR handshake in the same cycle, it SHALL take aw_addr_i.
REQ-023 err_cnt_o SHALL add 1 per accepted AW and 1 per accepted AR, adding 2 when both occur in the same cycle, and SHALL saturate at 16'hFFFF.
REQ-024 W beats presented while the write FSM is in W_IDLE SHALL stay unaccepted (w_ready_o=0); they SHALL NOT be dropped or counted.

Reset
REQ-025 While rst_i=1 at a clock edge, both FSMs SHALL go to IDLE, the beat counter, latched IDs, err_addr_o and err_cnt_o SHALL clear to 0, and err_o SHALL be 0.
REQ-026 In reset and the first cycle after it, the outputs SHALL be: aw_ready_o=1, ar_ready_o=1, w_ready_o=0, b_valid_o=0, r_valid_o=0, r_last_o=0.
REQ-027 Asserting reset mid-burst SHALL abandon the burst with no further B or R beats; the next transaction after reset SHALL be served normally.

Verification
REQ-028 Write burst: AW id=5'h13 addr=0x4000_0000, then 4 W beats with last on the 4th, b_ready=1 -> exactly one B with id 0x13 and resp 2'b11, err_addr_o=0x4000_0000, err_cnt_o=1.
REQ-029 Read burst: AR id=5'h07 len=3, r_ready=1 -> 4 R beats of 64'hDEAD_BEEF_DEAD_BEEF, resp 2'b11, id 0x07, r_last only on the 4th beat.
REQ-030 Backpressure: AR with len=0, r_ready held 0 for 5 cycles -> r_valid stays 1 and all R fields stay stable; ar_ready stays 0 until the R handshake.
REQ-031 Simultaneous events: AW addr=0x5000_0000 and AR addr=0x6000_0000 accepted in the same cycle -> err_cnt_o goes up by 2 and err_addr_o=0x5000_0000; both bursts complete independently.
REQ-032 Reset mid-operation: rst_i asserted during beat 2 of a 256-beat read -> r_valid_o=0 the next cycle; a following read with len=0 returns a single beat with r_last=1.
REQ-033 Saturation and max length: err_cnt_o forced to 16'hFFFF by 65535 single-beat reads, then one more read -> err_cnt_o stays 16'hFFFF; one read with len=255 -> exactly 256 beats.
